// File: rtl/pc_pkg.sv
// Shared opcode encoding and helpers for the program-counter sequencer.
package pc_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        INC  = 3'd1,
        JMP  = 3'd2,
        BR   = 3'd3,
        CALL = 3'd4,
        RET  = 3'd5
    } pc_op_t;

    localparam int SEXT_W = 32;

    // Sign-extend the low w bits of v to SEXT_W bits.
    function automatic logic [SEXT_W-1:0] sext32(input logic [SEXT_W-1:0] v,
                                                  input int unsigned      w);
        logic signed [SEXT_W-1:0] t;
        t = signed'(v << (SEXT_W - w));
        return unsigned'(t >>> (SEXT_W - w));
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO; push and pop are mutually exclusive at the caller.
module pc_ret_stack #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 7,
    parameter int SP_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic [SP_W-1:0]   sp,
    output logic              full,
    output logic              empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] mem_q [2**IDX_W];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [IDX_W-1:0]  wr_idx, top_idx;
    logic              wr_en;

    assign full  = (sp_q == SP_W'(DEPTH));
    assign empty = (sp_q == '0);
    assign sp    = sp_q;

    always_comb begin
        sp_d    = sp_q;
        wr_en   = 1'b0;
        wr_idx  = IDX_W'(sp_q);
        top_idx = IDX_W'(sp_q - SP_W'(1));
        if (clear) begin
            sp_d = '0;
        end else if (push && !full) begin
            sp_d  = sp_q + SP_W'(1);
            wr_en = 1'b1;
        end else if (pop && !empty) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    assign dout = mem_q[top_idx];

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) sp_q <= '0;
        else          sp_q <= sp_d;
    end

    // Entry contents are never reset; only entries below sp are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, jump, relative branch and call/return
// with a small return-address stack. All outputs are registered.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = 7,
    parameter int                OFF_W       = 5,
    parameter int                STACK_DEPTH = 4,
    parameter bit                WRAP_EN     = 1'b1,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    parameter int                SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              clear,
    input  logic              stall,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] target,
    input  logic [OFF_W-1:0]  offset,
    input  logic              cond,
    output logic [ADDR_W-1:0] address,
    output logic              done,
    output logic              stack_err,
    output logic [SP_W-1:0]   sp
);

    localparam logic [ADDR_W-1:0] MAX_ADDR = '1;

    logic [ADDR_W-1:0] address_q, address_d;
    logic              done_q, done_d;
    logic              stack_err_q, stack_err_d;

    logic              push, pop, full, empty;
    logic [ADDR_W-1:0] stk_dout;
    logic [ADDR_W-1:0] addr_plus1, br_addr, inc_addr;
    logic              inc_done;
    logic [SEXT_W-1:0] off_ext;

    pc_ret_stack #(
        .DEPTH  (STACK_DEPTH),
        .ADDR_W (ADDR_W),
        .SP_W   (SP_W)
    ) u_stack (
        .clk     (clk),
        .clear_n (clear_n),
        .clear   (clear),
        .push    (push),
        .pop     (pop),
        .din     (addr_plus1),
        .dout    (stk_dout),
        .sp      (sp),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        off_ext    = sext32(SEXT_W'(offset), OFF_W);
        addr_plus1 = address_q + ADDR_W'(1);
        br_addr    = address_q + off_ext[ADDR_W-1:0];
        // Saturating mode: once at the top (or already done) INC parks the address.
        if (!WRAP_EN && (done_q || address_q == MAX_ADDR)) begin
            inc_addr = address_q;
            inc_done = 1'b1;
        end else begin
            inc_addr = addr_plus1;
            inc_done = done_q;
        end
    end

    always_comb begin
        address_d   = address_q;
        done_d      = done_q;
        stack_err_d = stack_err_q;
        push        = 1'b0;
        pop         = 1'b0;
        if (clear) begin
            address_d   = RESET_ADDR;
            done_d      = 1'b0;
            stack_err_d = 1'b0;
        end else if (!stall) begin
            case (op)
                INC: begin
                    address_d = inc_addr;
                    done_d    = inc_done;
                end
                JMP: address_d = target;
                BR: begin
                    if (cond) begin
                        address_d = br_addr;
                    end else begin
                        address_d = inc_addr;
                        done_d    = inc_done;
                    end
                end
                CALL: begin
                    if (!full) begin
                        push      = 1'b1;
                        address_d = target;
                    end else begin
                        stack_err_d = 1'b1;
                    end
                end
                RET: begin
                    if (!empty) begin
                        pop       = 1'b1;
                        address_d = stk_dout;
                    end else begin
                        stack_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            address_q   <= RESET_ADDR;
            done_q      <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            address_q   <= address_d;
            done_q      <= done_d;
            stack_err_q <= stack_err_d;
        end
    end

    assign address   = address_q;
    assign done      = done_q;
    assign stack_err = stack_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a wrapping and a saturating instance share stimulus;
// a behavioural model is compared every cycle, plus directed literal checks.
module tb_pc_sequencer;
    import pc_pkg::*;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       clear = 1'b0;
    logic       stall = 1'b0;
    logic [2:0] op = 3'd0;
    logic [6:0] target = '0;
    logic [4:0] offset = '0;
    logic       cond = 1'b0;

    logic [6:0] addr_w, addr_s;
    logic       done_w, done_s, err_w, err_s;
    logic [2:0] sp_w, sp_s;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [6:0] m_addr [2];
    bit         m_done [2];
    bit         m_err  [2];
    int         m_sp   [2];
    logic [6:0] m_stk  [2][4];

    always #5 clk = ~clk;

    pc_sequencer #(.ADDR_W(7), .OFF_W(5), .STACK_DEPTH(4), .WRAP_EN(1'b1), .RESET_ADDR(7'd0)) u_wrap (
        .clk(clk), .clear_n(clear_n), .clear(clear), .stall(stall), .op(op),
        .target(target), .offset(offset), .cond(cond),
        .address(addr_w), .done(done_w), .stack_err(err_w), .sp(sp_w));

    pc_sequencer #(.ADDR_W(7), .OFF_W(5), .STACK_DEPTH(4), .WRAP_EN(1'b0), .RESET_ADDR(7'd0)) u_sat (
        .clk(clk), .clear_n(clear_n), .clear(clear), .stall(stall), .op(op),
        .target(target), .offset(offset), .cond(cond),
        .address(addr_s), .done(done_s), .stack_err(err_s), .sp(sp_s));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    task automatic model_inc(input int i, input bit wrap);
        if (wrap) m_addr[i] = 7'((int'(m_addr[i]) + 1) % 128);
        else if (m_done[i] || m_addr[i] == 7'd127) m_done[i] = 1'b1;
        else m_addr[i] = m_addr[i] + 7'd1;
    endtask

    task automatic model_step(input int i, input bit wrap);
        int off;
        int a;
        if (clear) begin
            m_addr[i] = 7'd0; m_done[i] = 1'b0; m_err[i] = 1'b0; m_sp[i] = 0;
        end else if (!stall) begin
            case (op)
                INC: model_inc(i, wrap);
                JMP: m_addr[i] = target;
                BR: begin
                    if (cond) begin
                        off = (int'(offset) >= 16) ? int'(offset) - 32 : int'(offset);
                        a = int'(m_addr[i]) + off;
                        m_addr[i] = 7'((a + 256) % 128);
                    end else begin
                        model_inc(i, wrap);
                    end
                end
                CALL: begin
                    if (m_sp[i] < 4) begin
                        m_stk[i][m_sp[i]] = 7'((int'(m_addr[i]) + 1) % 128);
                        m_sp[i]++;
                        m_addr[i] = target;
                    end else m_err[i] = 1'b1;
                end
                RET: begin
                    if (m_sp[i] > 0) begin
                        m_sp[i]--;
                        m_addr[i] = m_stk[i][m_sp[i]];
                    end else m_err[i] = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < 2; i++) begin
                m_addr[i] = 7'd0; m_done[i] = 1'b0; m_err[i] = 1'b0; m_sp[i] = 0;
            end
        end else begin
            model_step(0, 1'b1);
            model_step(1, 1'b0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_addr_w", addr_w, m_addr[0]);
            chk("model_done_w", done_w, m_done[0]);
            chk("model_err_w",  err_w,  m_err[0]);
            chk("model_sp_w",   sp_w,   m_sp[0]);
            chk("model_addr_s", addr_s, m_addr[1]);
            chk("model_done_s", done_s, m_done[1]);
            chk("model_err_s",  err_s,  m_err[1]);
            chk("model_sp_s",   sp_s,   m_sp[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [2:0] o, input logic [6:0] t = 7'd0,
                        input logic [4:0] f = 5'd0, input logic c = 1'b0,
                        input logic s = 1'b0, input logic cl = 1'b0);
        op = o; target = t; offset = f; cond = c; stall = s; clear = cl;
        @(posedge clk);
        #1;
        op = NOP; stall = 1'b0; clear = 1'b0; cond = 1'b0;
    endtask

    task automatic async_reset_pulse();
        @(negedge clk);
        #2 clear_n = 1'b0;
        #1;
        chk("async_addr_w", addr_w, 0);
        chk("async_addr_s", addr_s, 0);
        chk("async_done_s", done_s, 0);
        chk("async_sp_w", sp_w, 0);
        chk("async_err_w", err_w, 0);
        @(posedge clk);
        #1 clear_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 clear_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_addr", addr_w, 0);
        chk("rst_done", done_s, 0);
        chk("rst_err", err_w, 0);
        chk("rst_sp", sp_w, 0);

        // 1: count through the whole space
        repeat (127) step(INC);
        chk("inc127_w", addr_w, 127);
        chk("inc127_s", addr_s, 127);
        chk("inc127_done_s", done_s, 0);
        step(INC);
        chk("wrap_w", addr_w, 0);
        chk("sat_s", addr_s, 127);
        chk("sat_done_s", done_s, 1);
        repeat (2) step(INC);
        chk("inc130_w", addr_w, 2);
        chk("inc130_done_w", done_w, 0);
        repeat (40) step(INC);
        chk("inc170_w", addr_w, 42);
        async_reset_pulse();

        // 2: saturation and done stickiness
        step(JMP, 7'd125);
        step(INC); chk("s126", addr_s, 126);
        step(INC); chk("s127", addr_s, 127); chk("s127_done", done_s, 0);
        step(INC); chk("s127b", addr_s, 127); chk("s_done_rise", done_s, 1);
        chk("w_wrap2", addr_w, 0);
        step(INC); chk("s127c", addr_s, 127);
        step(JMP, 7'd10); chk("s_jmp10", addr_s, 10); chk("s_jmp_done", done_s, 1);
        step(INC); chk("s_inc_hold", addr_s, 10); chk("w_inc11", addr_w, 11);
        step(NOP, 7'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("s_clr_addr", addr_s, 0); chk("s_clr_done", done_s, 0);

        // 3: relative branches and stall
        step(JMP, 7'd3);
        step(BR, 7'd0, 5'h1B, 1'b1); chk("br_m5", addr_w, 126);
        step(BR, 7'd0, 5'd3, 1'b1);  chk("br_p3", addr_w, 1);
        step(BR, 7'd0, 5'd3, 1'b0);  chk("br_nt", addr_w, 2);
        step(JMP, 7'd50, 5'd0, 1'b0, 1'b1); chk("stall_jmp", addr_w, 2);

        // 4: call/return stack
        step(JMP, 7'd20);
        step(CALL, 7'd40); chk("call1", addr_w, 40); chk("call1_sp", sp_w, 1);
        step(CALL, 7'd60);
        step(CALL, 7'd80);
        step(CALL, 7'd100); chk("call4", addr_w, 100); chk("call4_sp", sp_w, 4);
        chk("call4_err", err_w, 0);
        step(CALL, 7'd5); chk("ovf_addr", addr_w, 100); chk("ovf_err", err_w, 1);
        chk("ovf_sp", sp_s, 4);
        step(RET); chk("ret1", addr_w, 81); chk("ret1_sp", sp_w, 3);
        step(RET); chk("ret2", addr_w, 61);
        step(RET); chk("ret3", addr_w, 41);
        step(RET); chk("ret4", addr_w, 21); chk("ret4_sp", sp_w, 0);
        chk("ret4_err", err_w, 1);

        // 5: underflow, sticky error, clear beats stall
        step(NOP, 7'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("clr_err", err_w, 0);
        step(RET); chk("unf_addr", addr_w, 0); chk("unf_err", err_w, 1);
        step(CALL, 7'd9); chk("err_call", addr_w, 9); chk("err_call_sp", sp_w, 1);
        step(JMP, 7'd44, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("clrstall_addr", addr_w, 0); chk("clrstall_sp", sp_w, 0);
        chk("clrstall_err", err_w, 0);

        // reset with entries on the stack
        step(CALL, 7'd70); step(CALL, 7'd71); chk("pre_rst_sp", sp_w, 2);
        async_reset_pulse();

        // 6: undefined op and one-edge latency
        step(JMP, 7'd33); chk("jmp33", addr_w, 33);
        step(3'd7); chk("op7_addr", addr_w, 33); chk("op7_sp", sp_w, 0);
        chk("op7_err", err_w, 0);
        op = INC;
        #1 chk("lat_before", addr_w, 33);
        @(posedge clk);
        #1 chk("lat_after", addr_w, 34);
        op = NOP;
        @(posedge clk);
        #1 chk("nop_hold", addr_w, 34);

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
